seg7_bin_display: RTL

Parametrised multi-digit seven-segment display driver. It takes a WIDTH-bit unsigned binary value on a load strobe and converts it to digits: decimal via a sequential shift-add-3 (double-dabble) FSM, or hexadecimal directly. It registers active-low segment patterns for DIGITS displays (HEX0..HEX5 on the board).

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/seg7_hex.sv | 11 +
 rtl/seg7_bin_display.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and segment constants for the seven-segment display driver.
// Segment patterns are active-low: bit 6 = segment g, bit 0 = segment a.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Entry 15 (F) is listed first so that HEX_SEG[n] decodes nibble n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

endpackage

// File: rtl/seg7_hex.sv
// Combinational 4-bit to active-low seven-segment hex decoder.
module seg7_hex
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg7_bin_display.sv
// Binary to multi-digit seven-segment driver: double-dabble decimal or direct hex.
// Optional blink gating of the outputs is enabled with macro SEG7_BLINK_EN.
module seg7_bin_display
    import seg7_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DIGITS    = 6,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      value,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
`ifdef SEG7_BLINK_EN
    input  logic                  blink,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [DIGITS*7-1:0]   leds
);

    localparam int BW = 4 * DIGITS;
    localparam int XW = (WIDTH > BW) ? WIDTH : BW;
    localparam int CW = $clog2(WIDTH + 1);

    if (WIDTH < 1 || WIDTH > 27 || DIGITS < 1 || DIGITS > 8 || BLINK_DIV < 1) begin : g_bad_param
        $error("seg7_bin_display: parameter out of range");
    end

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                hex_q, hex_d;
    logic                blz_q, blz_d;
    logic                sticky_q, sticky_d;
    logic [DIGITS*7-1:0] leds_q, leds_d;
    logic                ovf_q, ovf_d;

    logic [BW-1:0]       adj;
    logic [BW+WIDTH-1:0] shv;

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        hex_d    = hex_q;
        blz_d    = blz_q;
        sticky_d = sticky_q;
        adj      = bcd_q;
        shv      = '0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d    = value;
                    hex_d    = hex_mode;
                    blz_d    = blank_lz;
                    bcd_d    = '0;
                    sticky_d = 1'b0;
                    if (hex_mode) begin
                        state_d = UPDATE;
                    end else begin
                        state_d = SHIFT;
                        cnt_d   = CW'(WIDTH);
                    end
                end
            end
            SHIFT: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
                end
                shv      = {adj, bin_q} << 1;
                bcd_d    = shv[BW+WIDTH-1:WIDTH];
                bin_d    = shv[WIDTH-1:0];
                // A one leaving the top nibble means the value needs more digits.
                sticky_d = sticky_q | adj[BW-1];
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = UPDATE;
            end
            UPDATE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The display is built from the next-state operands so that leds and
    // overflow change on the same edge that raises done.
    logic [XW-1:0]  wide;
    logic [BW-1:0]  digit_src;
    logic           ovf_now;
    logic [6:0]     raw_seg [DIGITS];
    logic [DIGITS*7-1:0] disp;
    logic           lead;

    assign wide      = XW'(bin_d);
    assign digit_src = hex_d ? wide[BW-1:0] : bcd_d;
    assign ovf_now   = hex_d ? (|(wide >> BW)) : sticky_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        seg7_hex u_hex (
            .nibble_i (digit_src[4*g +: 4]),
            .seg_o    (raw_seg[g])
        );
    end

    always_comb begin
        disp = '0;
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (digit_src[4*i +: 4] != 4'd0) lead = 1'b0;
            if (ovf_now)                         disp[7*i +: 7] = SEG_DASH;
            else if (blz_d && lead && (i != 0))  disp[7*i +: 7] = SEG_BLANK;
            else                                 disp[7*i +: 7] = raw_seg[i];
        end
    end

    always_comb begin
        leds_d = leds_q;
        ovf_d  = ovf_q;
        if (state_d == UPDATE) begin
            leds_d = disp;
            ovf_d  = ovf_now;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            hex_q    <= 1'b0;
            blz_q    <= 1'b0;
            sticky_q <= 1'b0;
            leds_q   <= {DIGITS{SEG_BLANK}};
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            hex_q    <= hex_d;
            blz_q    <= blz_d;
            sticky_q <= sticky_d;
            leds_q   <= leds_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == UPDATE);
    assign overflow = ovf_q;

`ifdef SEG7_BLINK_EN
    localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BCW-1:0] bcnt_q, bcnt_d;
    logic           phase_q, phase_d;

    always_comb begin
        bcnt_d  = bcnt_q + 1'b1;
        phase_d = phase_q;
        if (bcnt_q == BCW'(BLINK_DIV - 1)) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

    // Blanking only gates the outputs; the stored digits survive the off phase.
    assign leds = (blink && phase_q) ? {DIGITS{SEG_BLANK}} : leds_q;
`else
    assign leds = leds_q;
`endif

endmodule
